// File: rtl/regfile_bus_pkg.sv
// Shared types and constants for the register-file side
// of the 4-bit BUSREQ protocol.
package regfile_bus_pkg;

  localparam int DW_DEFAULT = 4;

  localparam logic [3:0] BUSREQ_IDLE      = 4'b0000;
  localparam logic [3:0] BUSREQ_NEXT_OPND = 4'b0011;
  localparam logic [3:0] BUSREQ_READ_REG  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_IDX,
    ST_SEND_VAL,
    ST_WRITEBACK
  } state_t;

  // True when a 4-bit register index addresses a real register.
  function automatic logic idx_in_range(
    input logic [3:0] a,
    input int         n
  );
    return {1'b0, a} < 5'(n);
  endfunction

endpackage

// File: rtl/regfile_array.sv
// NREGS x DW register storage: one write port where the core
// writeback beats the host, plus core and host read ports.
module regfile_array
  import regfile_bus_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          host_we,
  input  logic [3:0]    host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic [3:0]    core_raddr,
  output logic [DW-1:0] core_rdata,
  output logic [DW-1:0] host_rdata
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DW-1:0] regs [NREGS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  // Select the single write: core writeback has priority.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (wb_we && idx_in_range(wb_addr, NREGS)) begin
      we    = 1'b1;
      waddr = wb_addr[AW-1:0];
      wdata = wb_data;
    end else if (host_we && idx_in_range(host_addr, NREGS)) begin
      we    = 1'b1;
      waddr = host_addr[AW-1:0];
      wdata = host_wdata;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign core_rdata = idx_in_range(core_raddr, NREGS)
                    ? regs[core_raddr[AW-1:0]] : '0;
  assign host_rdata = idx_in_range(host_addr, NREGS)
                    ? regs[host_addr[AW-1:0]] : '0;

endmodule

// File: rtl/regfile_bus_responder.sv
// Register-file responder for the core's BUSREQ protocol:
// operand index/value service, result writeback, host access.
module regfile_bus_responder
  import regfile_bus_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = DW_DEFAULT,
  parameter int WB_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    busreq,
  input  logic [DW-1:0] core_result,
  input  logic          core_done,
  output logic [3:0]    opnd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          host_we,
  input  logic [3:0]    host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  input  logic          host_opnd_we,
  input  logic [3:0]    host_opnd,
  output logic [DW-1:0] last_result,
  output logic          err
);

  state_t        state;
  logic [3:0]    busreq_q;
  logic          done_q;
  logic [3:0]    next_opnd;
  logic [DW-1:0] core_rdata;
  logic          wb_we;
  logic          req_chg;
  logic          done_rise;
  logic          collide;

  assign wb_we     = (state == ST_WRITEBACK) && (WB_EN != 0);
  assign req_chg   = busreq != busreq_q;
  assign done_rise = core_done & ~done_q;
  assign collide   = wb_we && host_we
                   && (host_addr == opnd_idx)
                   && idx_in_range(opnd_idx, NREGS);

  regfile_array #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_addr    (opnd_idx),
    .wb_data    (core_result),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .core_raddr (opnd_idx),
    .core_rdata (core_rdata),
    .host_rdata (host_rdata)
  );

  // Request FSM; busreq_q/done_q advance only when IDLE accepts,
  // so a change that loses to a done edge stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busreq_q    <= '0;
      done_q      <= 1'b0;
      next_opnd   <= '0;
      opnd_idx    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      last_result <= '0;
      err         <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (host_opnd_we) next_opnd <= host_opnd;
      if (collide) err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          done_q <= core_done;
          if (done_rise) begin
            state <= ST_WRITEBACK;
          end else if (req_chg) begin
            busreq_q <= busreq;
            unique case (1'b1)
              (busreq == BUSREQ_NEXT_OPND): state <= ST_SEND_IDX;
              (busreq == BUSREQ_READ_REG):  state <= ST_SEND_VAL;
              (busreq == BUSREQ_IDLE):      state <= ST_IDLE;
              default:                      err   <= 1'b1;
            endcase
          end
        end
        ST_SEND_IDX: begin
          opnd_idx <= next_opnd;
          state    <= ST_IDLE;
        end
        ST_SEND_VAL: begin
          rd_data  <= core_rdata;
          rd_valid <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_WRITEBACK: begin
          last_result <= core_result;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_responder.sv
// Scenario bench for regfile_bus_responder with a read
// scoreboard and a reference register model.
module tb_regfile_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] busreq;
  logic [3:0] core_result;
  logic       core_done;
  logic [3:0] opnd_idx;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       host_we;
  logic [3:0] host_addr;
  logic [3:0] host_wdata;
  logic [3:0] host_rdata;
  logic       host_opnd_we;
  logic [3:0] host_opnd;
  logic [3:0] last_result;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model [16];

  regfile_bus_responder #(
    .NREGS (16),
    .DW    (4),
    .WB_EN (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .busreq       (busreq),
    .core_result  (core_result),
    .core_done    (core_done),
    .opnd_idx     (opnd_idx),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .host_opnd_we (host_opnd_we),
    .host_opnd    (host_opnd),
    .last_result  (last_result),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 4'd0;
  endtask

  task automatic host_write(input logic [3:0] a,
                            input logic [3:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
    model[a]   = d;
  endtask

  task automatic wait_rd(input string name);
    logic [3:0] exp;
    bit seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rd_valid) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: rd_valid timeout", name);
    end else if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected read rd_data=%0d", name, rd_data);
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin
        n_bad++;
        $display("FAIL %s: rd_data=%0d expected %0d",
                 name, rd_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    host_write(4'd1, 4'd7);
    busreq = 4'b0001;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({opnd_idx, rd_data, rd_valid, err} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_outs: idx=%0d rd=%0d v=%0b err=%0b expected 0",
               opnd_idx, rd_data, rd_valid, err);
    end
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      n_cmp++;
      if (host_rdata !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %0d expected 0", i, host_rdata);
      end
    end
    model_clear();
    busreq = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    int p0;
    host_write(4'd1, 4'd4);
    host_write(4'd2, 4'd5);
    host_write(4'd3, 4'd6);
    host_write(4'd4, 4'd3);
    host_opnd_we = 1'b1;
    host_opnd    = 4'd3;
    tick();
    host_opnd_we = 1'b0;
    busreq = 4'b0011;
    tick();
    n_cmp++;
    if (opnd_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL idx_early: got %0d expected 0", opnd_idx);
    end
    tick();
    n_cmp++;
    if (opnd_idx !== 4'd3) begin
      n_bad++;
      $display("FAIL idx_2clk: got %0d expected 3", opnd_idx);
    end
    tick();
    p0 = pulses;
    busreq = 4'b0001;
    exp_q.push_back(model[3]);
    wait_rd("read_r3");
    repeat (3) tick();
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL read_pulses: got %0d expected 1", pulses - p0);
    end
  endtask

  task automatic test_writeback();
    core_result = 4'd8;
    core_done   = 1'b1;
    tick();
    tick();
    model[3]  = 4'd8;
    host_addr = 4'd3;
    #1;
    n_cmp++;
    if (last_result !== 4'd8 || host_rdata !== model[3]) begin
      n_bad++;
      $display("FAIL wb: last=%0d r3=%0d expected 8/8",
               last_result, host_rdata);
    end
    core_result = 4'd11;
    repeat (4) tick();
    n_cmp++;
    if (last_result !== 4'd8 || host_rdata !== model[3]) begin
      n_bad++;
      $display("FAIL wb_held: last=%0d r3=%0d expected 8/8",
               last_result, host_rdata);
    end
    core_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_held_code();
    int p0;
    busreq = 4'b0000;
    repeat (3) tick();
    p0 = pulses;
    busreq = 4'b0001;
    exp_q.push_back(model[3]);
    wait_rd("held_read");
    repeat (8) tick();
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL held_pulses: got %0d expected 1", pulses - p0);
    end
    busreq = 4'b0000;
    repeat (3) tick();
    busreq = 4'b0001;
    exp_q.push_back(model[3]);
    wait_rd("reread");
    repeat (4) tick();
    n_cmp++;
    if (pulses - p0 !== 2) begin
      n_bad++;
      $display("FAIL toggle_pulses: got %0d expected 2", pulses - p0);
    end
  endtask

  task automatic test_collision();
    busreq = 4'b0000;
    repeat (3) tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pre: got %0b expected 0", err);
    end
    core_result = 4'd9;
    core_done   = 1'b1;
    tick();
    host_we    = 1'b1;
    host_addr  = 4'd3;
    host_wdata = 4'd1;
    tick();
    host_we  = 1'b0;
    model[3] = 4'd9;
    #1;
    n_cmp++;
    if (host_rdata !== model[3] || err !== 1'b1) begin
      n_bad++;
      $display("FAIL collide: r3=%0d err=%0b expected 9/1",
               host_rdata, err);
    end
    core_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_priority();
    core_result = 4'd12;
    core_done   = 1'b1;
    busreq      = 4'b0001;
    model[3]    = 4'd12;
    exp_q.push_back(model[3]);
    wait_rd("prio_read");
    n_cmp++;
    if (last_result !== 4'd12) begin
      n_bad++;
      $display("FAIL prio_last: got %0d expected 12", last_result);
    end
    core_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_illegal();
    int p0;
    busreq = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_rst: got %0b expected 0", err);
    end
    host_write(4'd2, 4'd5);
    p0 = pulses;
    busreq = 4'b0111;
    repeat (3) tick();
    host_addr = 4'd2;
    #1;
    n_cmp++;
    if (err !== 1'b1 || opnd_idx !== 4'd0 || rd_data !== 4'd0
        || host_rdata !== model[2] || pulses != p0) begin
      n_bad++;
      $display("FAIL illegal: err=%0b idx=%0d rd=%0d r2=%0d p=%0d expected 1/0/0/5/0",
               err, opnd_idx, rd_data, host_rdata, pulses - p0);
    end
    busreq = 4'b0000;
    repeat (10) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %0b expected 1", err);
    end
  endtask

  initial begin
    rst          = 1'b1;
    busreq       = 4'b0000;
    core_result  = 4'd0;
    core_done    = 1'b0;
    host_we      = 1'b0;
    host_addr    = 4'd0;
    host_wdata   = 4'd0;
    host_opnd_we = 1'b0;
    host_opnd    = 4'd0;
    model_clear();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_preload_read();
    test_writeback();
    test_held_code();
    test_collision();
    test_priority();
    test_illegal();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d reads left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
